mem_align_unit: RTL and testbench
=================================

MEM_ALIGN_UNIT -- requirements
Module: mem_align_unit

Interface
REQ-001 Parameter DW, default 32, data width in bits; legal values 32 and 64; NB = DW/8 byte lanes.
REQ-002 Parameter AW, default 32, byte-address width.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 cpurst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid / req_ready  input / output  1 / 1  request handshake; a request is accepted when both are high on a clock edge.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-008 req_signed  input  1  sign-extend load data.
REQ-009 req_addr  input  AW  byte address.
REQ-010 req_wdata  input  DW  store data, right-justified.
REQ-011 req_rd  input  5  load destination register index.
REQ-012 mem_cs, mem_we  output  1, 1  SRAM chip select and write enable.
REQ-013 mem_addr  output  AW  NB-aligned beat address.
REQ-014 mem_ben  output  NB  per-byte-lane enable.
REQ-015 mem_wdata  output  DW  lane-positioned store data.
REQ-016 mem_gnt  input  1  SRAM accepts the current beat this cycle.
REQ-017 mem_rvalid, mem_rdata  input  1, DW  read data; arrives exactly one cycle after a granted read beat.
REQ-018 rsp_valid, rsp_wr_reg, rsp_err  output  1, 1, 1  one-cycle completion pulse; write-register flag (loads only); illegal-size flag.
REQ-019 rsp_rd, rsp_rdata  output  5, DW  destination register index; extended load result.
REQ-020 split_cnt  output  16  saturating count of split (misaligned) accesses.

Function
REQ-021 FSM states: IDLE, B0, B1, LWAIT, RESP. req_ready is high only in IDLE with cpurst_n high.
REQ-022 Request accept (cycle T): latch we, size, signed, addr, wdata and rd; next state is B0; an illegal size goes to RESP instead.
REQ-023 Illegal size is size=3 with DW=32: produces rsp_valid=1, rsp_err=1, rsp_wr_reg=0 and never asserts mem_cs.
REQ-024 Derived quantities: off = addr mod NB; nbytes = 2^size; split = (off + nbytes > NB).
REQ-025 Beat 0: mem_addr = addr with low log2(NB) bits cleared; mem_ben = ((2^nbytes - 1) << off) truncated to NB bits; mem_wdata = wdata << 8*off.
REQ-026 Beat 1 (split only): mem_addr = beat-0 address + NB, modulo 2^AW (wraps); mem_ben = bits of the beat-0 mask above NB-1; mem_wdata = wdata >> 8*(NB-off).
REQ-027 In B0 and B1, mem_cs=1 and mem_we=latched we; the state holds until mem_gnt=1.
REQ-028 On mem_gnt in B0: go to B1 if split; otherwise go to RESP (store) or LWAIT (load).
REQ-029 On mem_gnt in B1: go to RESP (store) or LWAIT (load). A beat-0 mem_rvalid that arrives during B1 is captured.
REQ-030 LWAIT holds until the last beat's mem_rvalid, captures it, then goes to RESP.
REQ-031 Load merge: {rdata1, rdata0} >> 8*off, keep the low nbytes bytes, then sign- or zero-extend to DW; rdata1 = 0 when not split.
REQ-032 RESP drives rsp_valid=1 for exactly one cycle, then returns to IDLE. rsp_rdata, rsp_rd and rsp_wr_reg are registered and valid only with rsp_valid; rsp_rdata=0 for stores.
REQ-033 Latency, with mem_gnt high on first assertion: aligned store rsp_valid at T+2; aligned load at T+3; split store at T+3; split load at T+4.
REQ-034 split_cnt increments once per accepted legal split request on its B0 grant and saturates at 0xFFFF.
REQ-035 Outside B0 and B1, mem_cs=0, mem_we=0, mem_ben=0, mem_addr=0 and mem_wdata=0.
REQ-036 mem_rvalid outside B1 and LWAIT is ignored.

Reset
REQ-037 cpurst_n low asynchronously forces state IDLE and clears all registers and outputs to 0, including split_cnt; req_ready=0 while reset is held.
REQ-038 Reset mid-operation (any state) drops mem_cs in the same cycle and abandons the access; no rsp_valid is issued for it.
REQ-039 After cpurst_n rises, req_ready=1 at the first clock edge.

Verification (DW=32)
REQ-040 SW addr 0x100, data 0xDEADBEEF -> one beat: mem_addr 0x100, ben 1111, wdata 0xDEADBEEF; rsp_valid at T+2.
REQ-041 SW addr 0x103, data 0x11223344 -> beat 0: 0x100, ben 1000, wdata 0x44000000; beat 1: 0x104, ben 0111, wdata 0x00112233; split_cnt=1.
REQ-042 Signed LH addr 0x203, rdata0 0xAB000000, rdata1 0x000000CD -> rsp_rdata 0xFFFFCDAB, rsp_wr_reg=1, rsp_valid at T+4.
REQ-043 Unsigned LB addr 0x002, rdata 0x00800000 -> rsp_rdata 0x00000080; signed LB -> 0xFFFFFF80.
REQ-044 size=3 -> rsp_err=1 at T+1 with mem_cs never high. SH addr 0xFFFFFFFF -> beat-1 mem_addr 0x00000000, ben 0001.
REQ-045 cpurst_n low during B1 with mem_gnt held low -> mem_cs=0 immediately, no rsp_valid, split_cnt=0; req_ready=1 after release.

Source files
------------

// File: rtl/mem_align_unit.sv
// mem_align_unit: aligns byte/half/word/dword loads and stores onto an NB-lane SRAM, splitting misaligned accesses into two beats
// Ports: clk, cpurst_n (async active-low); req_* request channel with req_valid/req_ready handshake;
//        mem_* SRAM beat channel (mem_gnt accepts a beat, mem_rvalid/mem_rdata return one cycle later);
//        rsp_* one-cycle completion (rsp_rdata extended load result, rsp_err illegal size); split_cnt saturating split counter
module mem_align_unit #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            cpurst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  input  logic [4:0]      req_rd,
  output logic            mem_cs,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_ben,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            rsp_valid,
  output logic            rsp_wr_reg,
  output logic            rsp_err,
  output logic [4:0]      rsp_rd,
  output logic [DW-1:0]   rsp_rdata,
  output logic [15:0]     split_cnt
);
  localparam int NB = DW / 8;
  localparam int LB = $clog2(NB);
  localparam int BW = 2 * NB;
  localparam int SW = LB + 1;
  typedef enum logic [2:0] {IDLE, B0, B1, LWAIT, RESP} state_t;
  state_t state, state_n;
  logic we_q, sgn_q, err_q;
  logic [1:0] size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wd_q, r0_q, rdata_q;
  logic [4:0] rd_q;
  logic [LB-1:0] off;
  logic [3:0] nb;
  logic split, sb, ill;
  logic [BW-1:0] bm;
  logic [AW-1:0] base;
  logic [SW-1:0] rem;
  logic [DW-1:0] cat, keep, merged;
  assign off = addr_q[LB-1:0];
  assign nb = 4'd1 << size_q;
  assign split = 5'(off) + 5'(nb) > 5'(NB);
  // two-beat byte mask: low NB bits go to beat 0, high NB bits to beat 1
  assign bm = ((BW'(1) << nb) - BW'(1)) << off;
  assign base = {addr_q[AW-1:LB], {LB{1'b0}}};
  assign rem = SW'(NB) - SW'(off);
  // mem_rdata is always the last beat here; r0_q holds beat 0 of a split load
  assign cat = DW'((split ? {mem_rdata, r0_q} : {{DW{1'b0}}, mem_rdata}) >> {off, 3'b000});
  // shifting past DW wraps to zero, so the full-width case yields all ones
  assign keep = (DW'(1) << {nb, 3'b000}) - DW'(1);
  assign sb = size_q == 2'd0 ? cat[7] : size_q == 2'd1 ? cat[15] : size_q == 2'd2 ? cat[31] : cat[DW-1];
  assign merged = (cat & keep) | (~keep & {DW{sgn_q & sb}});
  assign ill = req_size == 2'd3 && DW == 32;
  assign req_ready = state == IDLE && cpurst_n;
  assign rsp_valid = state == RESP;
  assign rsp_err = rsp_valid & err_q;
  assign rsp_wr_reg = rsp_valid & ~we_q & ~err_q;
  assign rsp_rd = rsp_valid ? rd_q : 5'd0;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  always_comb begin
    state_n = state;
    mem_cs = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_ben = '0;
    mem_wdata = '0;
    case (state)
      IDLE: if (req_valid) state_n = ill ? RESP : B0;
      B0: begin
        mem_cs = 1'b1;
        mem_we = we_q;
        mem_addr = base;
        mem_ben = bm[NB-1:0];
        mem_wdata = wd_q << {off, 3'b000};
        if (mem_gnt) state_n = split ? B1 : we_q ? RESP : LWAIT;
      end
      B1: begin
        mem_cs = 1'b1;
        mem_we = we_q;
        mem_addr = base + AW'(NB);
        mem_ben = bm[BW-1:NB];
        mem_wdata = wd_q >> {rem, 3'b000};
        if (mem_gnt) state_n = we_q ? RESP : LWAIT;
      end
      LWAIT: if (mem_rvalid) state_n = RESP;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      state <= IDLE;
      we_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      size_q <= 2'd0;
      addr_q <= '0;
      wd_q <= '0;
      rd_q <= 5'd0;
      r0_q <= '0;
      rdata_q <= '0;
      split_cnt <= 16'd0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        we_q <= req_we;
        sgn_q <= req_signed;
        size_q <= req_size;
        addr_q <= req_addr;
        wd_q <= req_wdata;
        rd_q <= req_rd;
        err_q <= ill;
        rdata_q <= '0;
      end
      if (state == B1 && mem_rvalid) r0_q <= mem_rdata;
      if (state == LWAIT && mem_rvalid) rdata_q <= merged;
      if (state == B0 && mem_gnt && split && split_cnt != 16'hFFFF) split_cnt <= split_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_mem_align_unit.sv
// tb_mem_align_unit: directed and randomized checks of mem_align_unit against a byte-level memory reference model
module tb_mem_align_unit;
  logic clk = 1'b0;
  logic cpurst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [4:0] req_rd = '0;
  logic req_ready, mem_cs, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0] mem_ben;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic rsp_valid, rsp_wr_reg, rsp_err;
  logic [4:0] rsp_rd;
  logic [31:0] rsp_rdata;
  logic [15:0] split_cnt;

  always #5 clk = ~clk;

  mem_align_unit #(.DW(32), .AW(32)) dut (
    .clk(clk), .cpurst_n(cpurst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ben(mem_ben), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .rsp_valid(rsp_valid),
    .rsp_wr_reg(rsp_wr_reg), .rsp_err(rsp_err), .rsp_rd(rsp_rd), .rsp_rdata(rsp_rdata), .split_cnt(split_cnt)
  );

  typedef struct {logic we; logic [31:0] addr; logic [3:0] ben; logic [31:0] wdata;} beat_t;
  beat_t beats[$];
  bit [7:0] sim_mem[bit [31:0]];
  bit [7:0] ref_mem[bit [31:0]];
  int gnt_mode = 0;
  bit pend = 1'b0;
  logic [31:0] pend_data = '0;
  int tests = 0, fails = 0, exp_split = 0, lat;
  logic [31:0] r_rdata, e_rdata;
  logic r_wr, r_er, r_one, e_wr, e_er;
  logic [4:0] r_rd;

  function automatic bit [7:0] sim_rd(input bit [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : 8'h00;
  endfunction

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [68:0] bt(input int i);
    if (i < beats.size()) return {beats[i].we, beats[i].addr, beats[i].ben, beats[i].wdata};
    return '1;
  endfunction

  // SRAM responder: grants on the falling edge, returns read data one cycle after a grant
  always @(negedge clk) begin
    mem_rvalid = pend;
    mem_rdata = pend ? pend_data : '0;
    pend = 1'b0;
    mem_gnt = gnt_mode == 0 ? 1'b1 : gnt_mode == 1 ? ($urandom_range(0, 2) != 0) : 1'b0;
    if (mem_cs && mem_gnt) begin
      beats.push_back('{mem_we, mem_addr, mem_ben, mem_wdata});
      if (mem_we) begin
        for (int i = 0; i < 4; i++) if (mem_ben[i]) sim_mem[mem_addr + 32'(i)] = mem_wdata[8*i+:8];
      end else begin
        for (int i = 0; i < 4; i++) pend_data[8*i+:8] = sim_rd(mem_addr + 32'(i));
        pend = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: an access touches nbytes consecutive bytes starting at addr, wrapping at 2^32
  task automatic model(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
    int n;
    logic [63:0] m;
    e_er = sz == 2'd3;
    e_wr = !we && !e_er;
    e_rdata = '0;
    if (!e_er) begin
      n = 1 << sz;
      if (int'(a % 4) + n > 4) exp_split++;
      for (int i = 0; i < n; i++) begin
        if (we) ref_mem[a + 32'(i)] = wd[8*i+:8];
        else e_rdata[8*i+:8] = ref_rd(a + 32'(i));
      end
      m = (64'd1 << (8 * n)) - 64'd1;
      if (!we && sg && e_rdata[8*n-1]) e_rdata = e_rdata | ~m[31:0];
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    int w = 0;
    model(we, sz, sg, a, wd);
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    beats.delete();
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
    r_rdata = rsp_rdata; r_wr = rsp_wr_reg; r_er = rsp_err; r_rd = rsp_rd;
    @(negedge clk);
    r_one = !rsp_valid && req_ready;
  endtask

  initial begin
    int seen;
    logic [1:0] sz;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_mem", {mem_cs, mem_we, mem_addr, mem_ben, mem_wdata}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_wr_reg, rsp_rd, rsp_rdata}, 0);
    chk("rst_split", split_cnt, 0);
    cpurst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", req_ready, 1);

    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 5'd1);
    chk("sw_lat", lat, 2);
    chk("sw_nbeats", beats.size(), 1);
    chk("sw_b0", bt(0), {1'b1, 32'h100, 4'b1111, 32'hDEADBEEF});
    chk("sw_rsp", {r_er, r_wr, r_rdata}, 0);
    chk("sw_onecyc", r_one, 1);
    chk("idle_mem", {mem_cs, mem_we, mem_addr, mem_ben, mem_wdata}, 0);

    do_req(1'b1, 2'd2, 1'b0, 32'h103, 32'h11223344, 5'd2);
    chk("swm_lat", lat, 3);
    chk("swm_b0", bt(0), {1'b1, 32'h100, 4'b1000, 32'h44000000});
    chk("swm_b1", bt(1), {1'b1, 32'h104, 4'b0111, 32'h00112233});
    chk("swm_split", split_cnt, 1);

    sim_mem[32'h203] = 8'hAB; ref_mem[32'h203] = 8'hAB;
    sim_mem[32'h204] = 8'hCD; ref_mem[32'h204] = 8'hCD;
    do_req(1'b0, 2'd1, 1'b1, 32'h203, 32'h0, 5'd7);
    chk("lh_lat", lat, 4);
    chk("lh_rdata", r_rdata, 32'hFFFFCDAB);
    chk("lh_model", r_rdata, e_rdata);
    chk("lh_wr_rd", {r_wr, r_rd, r_er}, {1'b1, 5'd7, 1'b0});
    chk("lh_b0", bt(0), {1'b0, 32'h200, 4'b1000, 32'h0});
    chk("lh_b1", bt(1), {1'b0, 32'h204, 4'b0001, 32'h0});
    chk("lh_onecyc", r_one, 1);

    sim_mem[32'h002] = 8'h80; ref_mem[32'h002] = 8'h80;
    do_req(1'b0, 2'd0, 1'b0, 32'h002, 32'h0, 5'd3);
    chk("lbu_lat", lat, 3);
    chk("lbu_rdata", r_rdata, 32'h00000080);
    chk("lbu_b0", bt(0), {1'b0, 32'h0, 4'b0100, 32'h0});
    do_req(1'b0, 2'd0, 1'b1, 32'h002, 32'h0, 5'd4);
    chk("lb_rdata", r_rdata, 32'hFFFFFF80);

    do_req(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 5'd5);
    chk("ill_lat", lat, 1);
    chk("ill_rsp", {r_er, r_wr, r_rdata}, {1'b1, 1'b0, 32'h0});
    chk("ill_nocs", beats.size(), 0);

    do_req(1'b1, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0000BEEF, 5'd6);
    chk("shw_b0", bt(0), {1'b1, 32'hFFFFFFFC, 4'b1000, 32'hEF000000});
    chk("shw_b1", bt(1), {1'b1, 32'h00000000, 4'b0001, 32'h000000BE});
    chk("split_model", split_cnt, 16'(exp_split));

    // reset while a split load waits in B1 without a grant
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h103; req_rd = 5'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rb_b0_cs", mem_cs, 1);
    @(posedge clk); #1;
    gnt_mode = 2;
    @(negedge clk);
    chk("rb_b1", {mem_cs, mem_ben}, {1'b1, 4'b0111});
    #2 cpurst_n = 1'b0;
    #1;
    chk("rb_cs_drop", {mem_cs, rsp_valid, req_ready}, 0);
    chk("rb_split", split_cnt, 0);
    @(negedge clk);
    cpurst_n = 1'b1;
    gnt_mode = 0;
    @(posedge clk); #1;
    chk("rb_ready", req_ready, 1);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | int'(rsp_valid);
    end
    chk("rb_no_rsp", seen, 0);
    exp_split = 0;

    gnt_mode = 1;
    for (int k = 0; k < 150; k++) begin
      sz = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7) : 32'($urandom_range(0, 63));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)));
      chk($sformatf("r%0d_done", k), lat > 0, 1);
      chk($sformatf("r%0d_rsp", k), {r_er, r_wr, r_rdata}, {e_er, e_wr, e_rdata});
      chk($sformatf("r%0d_rd", k), r_rd, req_rd);
      chk($sformatf("r%0d_onecyc", k), r_one, 1);
    end
    chk("r_split", split_cnt, 16'(exp_split));
    foreach (ref_mem[k]) chk($sformatf("mem_%0h", k), sim_rd(k), ref_mem[k]);
    foreach (sim_mem[k]) chk($sformatf("extra_%0h", k), sim_mem[k], ref_rd(k));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
